// File: rtl/pipe_pkg.sv
// Shared fetch-stage types: FSM states, NOP encoding and the IF/ID record.
package pipe_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W   = 3;

  localparam logic [INSTR_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    VEC
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } ifid_t;

endpackage

// File: rtl/int_seq.sv
// Interrupt entry sequencer: drains the pipeline, then hands the vector
// fetch back to fetch_ctrl and raises a one-cycle inject/ack pair.
module int_seq
  import pipe_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            int_req,
  input  logic [PC_W-1:0] pc,
  output state_t          state,
  output logic [PC_W-1:0] ret_pc,
  output logic            take_c,
  output logic            int_inject,
  output logic            int_ack
);

  logic [CNT_W-1:0] cnt;

  // Entry is only taken on a cycle the fetch stage would otherwise advance.
  assign take_c = (state == RUN) && int_req && !stall && !flush;

  // Sequencer state, drain counter and captured return PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= '0;
      ret_pc     <= '0;
      int_inject <= 1'b0;
      int_ack    <= 1'b0;
    end else begin
      int_inject <= 1'b0;
      int_ack    <= 1'b0;
      unique case (state)
        RUN: begin
          if (take_c) begin
            ret_pc <= pc;
            cnt    <= CNT_W'(DRAIN_CYC - 1);
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          // A branch resolving while draining moves the return point.
          if (flush && redirect_valid) ret_pc <= redirect_pc;
          if (!(stall && !flush)) begin
            if (cnt == '0) state <= VEC;
            else           cnt   <= cnt - CNT_W'(1);
          end
        end
        VEC: begin
          if (flush) begin
            if (redirect_valid) ret_pc <= redirect_pc;
          end else if (!stall) begin
            int_inject <= 1'b1;
            int_ack    <= 1'b1;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: PC register, IF/ID buffer, stall/flush handling.
// Interrupt sequencing is built only when FETCH_INT_EN is defined.
module fetch_ctrl
  import pipe_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = 16'h0020,
  parameter logic [PC_W-1:0] INT_VEC_ADDR = 16'h0001,
  parameter int unsigned     DRAIN_CYC    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               int_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               int_inject,
  output logic               int_ack
);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] ret_pc;
  logic            take_c;
  ifid_t           ifid;

`ifdef FETCH_INT_EN
  int_seq #(
    .DRAIN_CYC(DRAIN_CYC)
  ) u_int_seq (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .int_req       (int_req),
    .pc            (pc),
    .state         (state),
    .ret_pc        (ret_pc),
    .take_c        (take_c),
    .int_inject    (int_inject),
    .int_ack       (int_ack)
  );
`else
  logic unused_int;
  assign state      = RUN;
  assign ret_pc     = '0;
  assign take_c     = 1'b0;
  assign int_inject = 1'b0;
  assign int_ack    = 1'b0;
  assign unused_int = ^{int_req, CNT_W'(DRAIN_CYC)};
`endif

  assign pc_inc     = pc + PC_W'(1);
  assign imem_addr  = (state == VEC) ? INT_VEC_ADDR : pc;
  assign ifid_valid = ifid.valid;
  assign ifid_instr = ifid.instr;
  assign ifid_pc    = ifid.pc;

  // PC and IF/ID update; flush beats stall in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= RESET_PC;
      ifid <= '{valid: 1'b0, instr: NOP, pc: '0};
    end else begin
      unique case (state)
        RUN: begin
          if (flush) begin
            ifid.valid <= 1'b0;
            ifid.instr <= NOP;
            if (redirect_valid) pc <= redirect_pc;
          end else if (!stall) begin
            if (take_c) begin
              ifid.valid <= 1'b0;
              ifid.instr <= NOP;
            end else begin
              ifid <= '{valid: 1'b1, instr: imem_data, pc: pc_inc};
              pc   <= pc_inc;
            end
          end
        end
        DRAIN: begin
          ifid.valid <= 1'b0;
          ifid.instr <= NOP;
        end
        VEC: begin
          if (flush) begin
            ifid.valid <= 1'b0;
            ifid.instr <= NOP;
          end else if (!stall) begin
            pc   <= PC_W'(imem_data);
            ifid <= '{valid: 1'b1, instr: NOP, pc: ret_pc};
          end
        end
        default: begin
          ifid.valid <= 1'b0;
          ifid.instr <= NOP;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage controller that applies the `stall`/`flush` decisions issued by the hazard detection unit. It owns the PC register and the IF/ID pipeline buffer, and sequences interrupt entry. On a stall it holds the stage; on a flush it inserts a bubble and redirects the PC. On an interrupt it drains the pipeline, fetches the handler vector and injects a return-PC pseudo-instruction for the push logic downstream.

## Interface
- `PC_W`, 16: PC and vector width; instruction memory is word-addressed.
- `INSTR_W`, 16: instruction width.
- `RESET_PC`, 16'h0020: PC after reset.
- `INT_VEC_ADDR`, 16'h0001: memory word holding the interrupt handler address.
- `DRAIN_CYC`, 2: number of bubble cycles before the vector fetch; legal range 1..7.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: hold PC and IF/ID (load-use hazard).
- `flush` in 1: kill the IF/ID content.
- `redirect_valid` in 1: the `redirect_pc` target accompanies the flush (jmp/call/ret/rti).
- `redirect_pc` in PC_W: branch or return target.
- `int_req` in 1: level interrupt request.
- `imem_addr` out PC_W: combinational instruction memory address.
- `imem_data` in INSTR_W: same-cycle read data.
- `ifid_valid` out 1, `ifid_instr` out INSTR_W, `ifid_pc` out PC_W: IF/ID buffer; `ifid_pc` = PC+1 of the fetched word.
- `int_inject` out 1: IF/ID holds the interrupt pseudo-instruction, with `ifid_pc` = return PC.
- `int_ack` out 1: one-cycle acknowledge.

## Operation
- States: RUN, DRAIN, VEC.
- Update priority: `rst` > `flush` > `stall` > normal.
- RUN, normal: `imem_addr`=pc. At the edge:
  - IF/ID <= {1, imem_data, pc+1}.
  - pc <= pc+1, wrapping modulo 2^PC_W.
- RUN, stall: pc and IF/ID hold.
- RUN, flush:
  - ifid_valid<=0 and ifid_instr<=NOP (all zeros).
  - pc <= redirect_pc if `redirect_valid`, else pc holds.
- Interrupt entry: in RUN with `int_req`=1, `stall`=0, `flush`=0:
  - ret_pc<=pc; IF/ID<=bubble; cnt<=DRAIN_CYC-1; go to DRAIN.
  - If `int_req` coincides with a flush or stall, the flush/stall is served first and entry is re-evaluated next cycle.
- DRAIN: every cycle IF/ID<=bubble and pc holds.
  - Stall: cnt holds.
  - Flush with redirect: ret_pc<=redirect_pc. This is the in-flight branch's target; the PC is not changed.
  - cnt==0 and !stall: go to VEC. Otherwise cnt decrements.
- VEC: `imem_addr`=INT_VEC_ADDR.
  - Stall: hold in VEC.
  - Otherwise at the edge: pc<=imem_data; IF/ID<={1, NOP, ret_pc}; int_inject<=1; int_ack<=1; go to RUN.
- `int_inject` and `int_ack` clear at the next edge.
- `int_req` must drop within the cycle after `int_ack`. If it is still high in RUN, a new entry is taken.

## Timing
- Reset values: pc=RESET_PC, state=RUN, ifid_valid=0, ifid_instr=NOP, ifid_pc=0, int_inject=0, int_ack=0, cnt=0, ret_pc=0.
- Fetch latency: a word addressed in cycle N is in IF/ID in cycle N+1.
- Redirect: the target is fetched in the cycle after the flush edge.
- Interrupt latency: `int_req` sampled at edge E (no stall) gives `int_ack` and `int_inject` high after edge E+DRAIN_CYC+1. Each stall cycle adds 1.
- Reset asserted mid-sequence (DRAIN or VEC) aborts the sequence: no ack, state RUN.
- Simultaneous `flush`+`stall`: flush wins in every state.

## Configuration
- `FETCH_INT_EN` defined: the interrupt sequencer (DRAIN, VEC, cnt, ret_pc) is built.
- `FETCH_INT_EN` undefined: only RUN exists; `int_req` is ignored; `int_inject` and `int_ack` are tied to 0.

## Structure
- Shared package `pipe_pkg`: state enum {RUN, DRAIN, VEC}, NOP constant, IF/ID record typedef {valid, instr, pc}.
- Sub-module `int_seq`: the DRAIN/VEC state machine, drain counter and ret_pc register. It is instantiated only under `FETCH_INT_EN`.

## Test plan
- Reset then 4 free-running cycles:
  - imem_addr = 0x20, 0x21, 0x22, 0x23.
  - ifid_pc = 0x21..0x24 with valid=1 from the second cycle.
- Stall held 2 cycles at pc=0x22: imem_addr stays 0x22 and IF/ID is unchanged. On release, the 0x22 word enters with ifid_pc=0x23.
- Flush with redirect_pc=0x40: next cycle ifid_valid=0 and imem_addr=0x40. Flush without redirect: pc holds and a bubble is inserted.
- int_req at pc=0x25 with mem[0x1]=0x0100, DRAIN_CYC=2:
  - 2 bubbles, then imem_addr=0x1.
  - Then int_ack=1, int_inject=1, ifid_pc=0x25, and next imem_addr=0x100.
- Flush with redirect_pc=0x30 during DRAIN, plus one stall cycle: the injected ifid_pc is 0x30 and ack is delayed by 1 cycle.
- rst pulsed while in VEC: no int_ack, and pc=0x20 after the reset.
